// File: rtl/gomoku_board_render.sv
// Gomoku board renderer: 15x15 stone store with a sweeping clear and a 2-stage pixel pipeline.
// Optional feature macro: CURSOR_EN (draws an outline on cell cur_row/cur_col).
module gomoku_board_render #(
  parameter int BX0  = 95,
  parameter int BY0  = 15,
  parameter int CELL = 30,
  parameter int N    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        sync_h_in,
  input  logic        sync_v_in,
  input  logic        wr_en,
  input  logic [3:0]  wr_row,
  input  logic [3:0]  wr_col,
  input  logic [1:0]  wr_val,
  input  logic        clr,
  input  logic [3:0]  cur_row,
  input  logic [3:0]  cur_col,
  output logic        busy,
  output logic [11:0] rgb,
  output logic        sync_h,
  output logic        sync_v
);
  localparam logic [9:0]         X_LO    = 10'(BX0);
  localparam logic [9:0]         X_HI    = 10'(BX0 + CELL * N);
  localparam logic [9:0]         Y_LO    = 10'(BY0);
  localparam logic [9:0]         Y_HI    = 10'(BY0 + CELL * N);
  localparam logic [4:0]         OFF_MAX = 5'(CELL - 1);
  localparam logic [3:0]         N4      = 4'(N);
  localparam logic [7:0]         N8      = 8'(N);
  localparam logic [7:0]         LAST    = 8'(N * N - 1);
  localparam logic signed [12:0] CTR     = 13'(CELL / 2);
  localparam logic signed [12:0] R2      = 13'sd144;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t      state_q;
  logic [7:0]  clr_addr_q;
  logic        busy_q;
  logic [1:0]  board_q [N*N];

  logic [4:0]  xoff_q, xoff_d, yoff_q, yoff_d;
  logic [3:0]  col_q, col_d, row_q, row_d;
  logic        in_board_q, in_board_d;
  logic [1:0]  cell_q, cell_d;
  logic        vo_q, hs_q, vs_q;
  logic [7:0]  rd_addr, wr_addr;
  logic        wr_ok;
  logic        cur_hit;
  logic [11:0] rgb_q, rgb_d;
  logic        sync_h_q, sync_v_q;

  function automatic logic in_disc(input logic [4:0] xo, input logic [4:0] yo);
    logic signed [12:0] dx, dy;
    dx = $signed({8'b0, xo}) - CTR;
    dy = $signed({8'b0, yo}) - CTR;
    return (dx * dx + dy * dy) <= R2;
  endfunction

`ifdef CURSOR_EN
  function automatic logic in_ring(input logic [4:0] o);
    return (o == 5'd1) || (o == 5'd2) || (o == OFF_MAX - 5'd2) || (o == OFF_MAX - 5'd1);
  endfunction

  assign cur_hit = (row_q == cur_row) && (col_q == cur_col) &&
                   (in_ring(xoff_q) || in_ring(yoff_q));
`else
  logic unused_cur;
  assign unused_cur = ^{cur_row, cur_col};
  assign cur_hit    = 1'b0;
`endif

  // Clear sweep: one address per clock; reset restarts it from address 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (clr) begin
          state_q    <= S_CLEAR;
          clr_addr_q <= '0;
          busy_q     <= 1'b1;
        end
        S_CLEAR: if (clr_addr_q == LAST) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else begin
          clr_addr_q <= clr_addr_q + 8'd1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_addr = {4'b0, wr_row} * N8 + {4'b0, wr_col};
  assign wr_ok   = rst && wr_en && !busy_q && (wr_row < N4) && (wr_col < N4);

  always_ff @(posedge clk) begin
    if (rst && busy_q) board_q[clr_addr_q] <= 2'b00;
    else if (wr_ok)    board_q[wr_addr]    <= wr_val;
  end

  // Stage 1: cell/offset counters track the raster scan instead of dividing x and y
  always_comb begin
    xoff_d = xoff_q + 5'd1;
    col_d  = col_q;
    if (x == X_LO) begin
      xoff_d = '0;
      col_d  = '0;
    end else if (xoff_q == OFF_MAX) begin
      xoff_d = '0;
      col_d  = col_q + 4'd1;
    end
    yoff_d = yoff_q;
    row_d  = row_q;
    if (x == 10'd0) begin
      if (y == Y_LO) begin
        yoff_d = '0;
        row_d  = '0;
      end else if (yoff_q == OFF_MAX) begin
        yoff_d = '0;
        row_d  = row_q + 4'd1;
      end else begin
        yoff_d = yoff_q + 5'd1;
      end
    end
    in_board_d = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
    rd_addr    = {4'b0, row_d} * N8 + {4'b0, col_d};
    cell_d     = ((row_d < N4) && (col_d < N4)) ? board_q[rd_addr] : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xoff_q     <= '0;
      yoff_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      in_board_q <= 1'b0;
      cell_q     <= '0;
      vo_q       <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      xoff_q     <= xoff_d;
      yoff_q     <= yoff_d;
      col_q      <= col_d;
      row_q      <= row_d;
      in_board_q <= in_board_d;
      cell_q     <= cell_d;
      vo_q       <= video_on;
      hs_q       <= sync_h_in;
      vs_q       <= sync_v_in;
    end
  end

  // Stage 2: colour priority; reserved cell value 3 falls through as empty
  always_comb begin
    rgb_d = 12'hDA6;
    if (!vo_q)                                        rgb_d = 12'h000;
    else if (!in_board_q)                             rgb_d = 12'h333;
    else if (cur_hit)                                 rgb_d = 12'hF00;
    else if (xoff_q == 5'd0 || yoff_q == 5'd0)        rgb_d = 12'h000;
    else if (in_disc(xoff_q, yoff_q) && cell_q == 2'd1) rgb_d = 12'h111;
    else if (in_disc(xoff_q, yoff_q) && cell_q == 2'd2) rgb_d = 12'hEEE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_q    <= 12'h000;
      sync_h_q <= 1'b1;
      sync_v_q <= 1'b1;
    end else begin
      rgb_q    <= rgb_d;
      sync_h_q <= hs_q;
      sync_v_q <= vs_q;
    end
  end

  assign busy   = busy_q;
  assign rgb    = rgb_q;
  assign sync_h = sync_h_q;
  assign sync_v = sync_v_q;
endmodule

// File: doc/gomoku_board_render.md
GOMOKU_BOARD_RENDER -- requirements
Module: gomoku_board_render

Interface
REQ-001 Parameters SHALL be:
- BX0, 95, board left pixel column.
- BY0, 15, board top pixel row.
- CELL, 30, cell size in pixels.
- N, 15, cells per side.
REQ-002 Ports SHALL be:
- clk  in  1  pixel clock, shared with the sync generator.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- x  in  10  current pixel column from the sync generator.
- y  in  10  current pixel row from the sync generator.
- video_on  in  1  active-area flag.
- sync_h_in  in  1  horizontal sync from the sync generator.
- sync_v_in  in  1  vertical sync from the sync generator.
- wr_en  in  1  stone write strobe.
- wr_row  in  4  write row, 0..14.
- wr_col  in  4  write column, 0..14.
- wr_val  in  2  cell value: 0 empty, 1 black, 2 white, 3 reserved.
- clr  in  1  start a board clear.
- cur_row  in  4  cursor row.
- cur_col  in  4  cursor column.
- busy  out  1  clear in progress.
- rgb  out  12  pixel colour, {R4,G4,B4}.
- sync_h  out  1  delayed horizontal sync.
- sync_v  out  1  delayed vertical sync.

Function
REQ-003 The block SHALL store a 15x15 array of 2-bit cells at address row*15+col.
REQ-004 Rendering SHALL be a 2-stage pipeline with a fixed latency of 2 clocks from x, y, video_on and sync inputs to rgb, sync_h and sync_v.
REQ-005 Stage 1 SHALL derive the cell index (col, row) and in-cell offset (xoff, yoff, 0..29) with counters, not division:
- xoff and col load 0 when x==BX0; otherwise xoff increments, and on wrap 29->0 col increments.
- yoff and row update only when x==0: load 0 when y==BY0; otherwise yoff increments, and on wrap 29->0 row increments.
REQ-006 in_board SHALL be true when BX0<=x<BX0+450 and BY0<=y<BY0+450; it is registered in stage 1.
REQ-007 Stage 2 SHALL register rgb using this priority, highest first:
- !video_on -> 0x000.
- !in_board -> 0x333.
- Cursor outline -> 0xF00.
- Grid line (xoff==0 or yoff==0) -> 0x000.
- Stone disc, (xoff-15)^2+(yoff-15)^2<=144, black cell -> 0x111.
- Stone disc, white cell -> 0xEEE.
- Otherwise -> 0xDA6.
REQ-008 Reserved cell value 3 SHALL render as empty.
REQ-009 The board read in stage 1 SHALL be read-before-write: a write to the same cell in the same cycle is visible from the next cycle onward.
REQ-010 Writes with wr_row>14 or wr_col>14 SHALL be ignored.
REQ-011 The clear FSM SHALL have two states:
- IDLE -> CLEAR on clr==1.
- CLEAR zeroes one address per clock, 0..224; after address 224 it returns to IDLE, so one clear takes exactly 225 clocks.
REQ-012 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-013 wr_en SHALL be ignored while busy==1.
REQ-014 clr asserted while busy==1 SHALL be ignored; it does not restart the sweep.
REQ-015 Rendering SHALL continue during CLEAR, reading the partially cleared array.

Reset
REQ-016 While rst==0 on a clock edge, the block SHALL force:
- rgb=0x000, sync_h=1, sync_v=1.
- All pipeline registers to 0.
- FSM=CLEAR with clear address 0, and busy=1.
REQ-017 After rst deasserts, the block SHALL complete a 225-clock clear before accepting writes.
REQ-018 Reset asserted mid-clear SHALL restart the sweep at address 0.

Configuration
REQ-019 With CURSOR_EN defined, the cursor outline SHALL be drawn on the cell (cur_row, cur_col) wherever xoff, yoff or both are in {1,2,27,28}.
REQ-020 With CURSOR_EN undefined, the cursor priority level SHALL be absent and cur_row/cur_col SHALL be unused; all other behaviour is unchanged.

Verification
REQ-021 Reset for 3 clocks, then release -> busy stays 1 for 225 clocks, then 0; wr_en during the busy window leaves every cell at 0.
REQ-022 Write (7,7)=1 after clear, then scan the frame -> at x=BX0+225, y=BY0+225, rgb=0x111 two clocks after that x/y is presented.
REQ-023 Pixel x=BX0, y=BY0+5 inside the board -> rgb=0x000 (grid line); x=BX0-1 -> rgb=0x333.
REQ-024 Present x=700 (video_on=0) with sync_h_in=0 -> 2 clocks later rgb=0x000 and sync_h=0.
REQ-025 With CURSOR_EN defined, cur=(0,0) -> pixel (BX0+1, BY0+10) gives rgb=0xF00; with CURSOR_EN undefined the same pixel gives 0xDA6.
REQ-026 Pulse clr at clear step 100, then apply rst=0 for 1 clock -> the sweep restarts at address 0 and busy lasts 225 clocks from the reset release.
